// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=3 rate-1/2 convolutional code.
// Used by the encoder and by the decoder's expected-codeword tables.
package viterbi_pkg;

    localparam int K          = 3;
    localparam int CODE_W     = 2;
    localparam int NUM_STATES = 4;

    // Tap order: bit 2 = u(n), bit 1 = u(n-1), bit 0 = u(n-2)
    localparam logic [K-1:0] G_UPPER = 3'b111;
    localparam logic [K-1:0] G_LOWER = 3'b101;

    // {s1, s2} = {u(n-1), u(n-2)}
    typedef logic [K-2:0] state_t;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL
    } enc_fsm_t;

    // Codeword {upper, lower} for input bit u leaving state s
    function automatic logic [CODE_W-1:0] conv_codeword(
        input logic   u,
        input state_t s
    );
        logic [K-1:0] r;
        r = {u, s};
        return {^(r & G_UPPER), ^(r & G_LOWER)};
    endfunction

endpackage

// File: rtl/conv_encoder_k3.sv
// Rate-1/2, K=3 convolutional encoder with optional zero-tail termination.
// Ports: i_clk/i_rst (async high), input bit stream i_valid/i_data/i_last
// with o_ready, codeword stream o_valid/o_code/o_last with i_ready, o_busy.
module conv_encoder_k3
    import viterbi_pkg::*;
#(
    parameter bit TAIL_EN = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic              i_data,
    input  logic              i_last,
    output logic              o_ready,
    output logic              o_valid,
    output logic [CODE_W-1:0] o_code,
    output logic              o_last,
    input  logic              i_ready,
    output logic              o_busy
);

    enc_fsm_t   fsm;
    state_t     s;
    logic [1:0] tail_cnt;

    logic load;
    logic accept;
    logic tail_step;
    logic out_hs;

    // Output register may take a new codeword when empty or draining
    assign load      = !o_valid || i_ready;
    assign o_ready   = (fsm != TAIL) && load;
    assign accept    = i_valid && o_ready;
    assign tail_step = (fsm == TAIL) && load;
    assign out_hs    = o_valid && i_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fsm      <= IDLE;
            s        <= '0;
            tail_cnt <= '0;
            o_valid  <= 1'b0;
            o_code   <= '0;
            o_last   <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            // Clear first so a back-to-back first accept can re-set it
            if (out_hs && o_last) begin
                o_busy <= 1'b0;
            end
            if (accept) begin
                o_code  <= conv_codeword(i_data, s);
                s       <= {i_data, s[K-2]};
                o_valid <= 1'b1;
                o_busy  <= 1'b1;
                if (i_last && TAIL_EN) begin
                    fsm      <= TAIL;
                    tail_cnt <= '0;
                    o_last   <= 1'b0;
                end else if (i_last) begin
                    fsm    <= IDLE;
                    o_last <= 1'b1;
                end else begin
                    fsm    <= DATA;
                    o_last <= 1'b0;
                end
            end else if (tail_step) begin
                o_code   <= conv_codeword(1'b0, s);
                s        <= {1'b0, s[K-2]};
                o_valid  <= 1'b1;
                tail_cnt <= tail_cnt + 2'd1;
                if (tail_cnt == 2'(K - 2)) begin
                    fsm    <= IDLE;
                    o_last <= 1'b1;
                end else begin
                    o_last <= 1'b0;
                end
            end else if (out_hs) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_encoder_k3.sv
// Directed self-checking bench for conv_encoder_k3.
// Drives a TAIL_EN=1 and a TAIL_EN=0 instance, selected by sel.
module tb_conv_encoder_k3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid = 1'b0;
    logic data = 1'b0;
    logic last = 1'b0;
    logic ready = 1'b1;
    logic sel = 1'b1;

    logic       v1, v0, r1, r0;
    logic       ordy1, ordy0, ov1, ov0, ol1, ol0, ob1, ob0;
    logic [1:0] oc1, oc0;

    logic       ordy, ov, ol, ob;
    logic [1:0] oc;

    int vectors = 0;
    int miscompares = 0;

    logic [2:0] cap[$];
    int         stall_err = 0;
    int         rdy_low = 0;
    logic       hold_prev = 1'b0;
    logic [2:0] held = 3'b000;

    always #5 clk = ~clk;

    assign v1 = sel ? valid : 1'b0;
    assign v0 = sel ? 1'b0 : valid;
    assign r1 = sel ? ready : 1'b1;
    assign r0 = sel ? 1'b1 : ready;

    assign ordy = sel ? ordy1 : ordy0;
    assign ov   = sel ? ov1 : ov0;
    assign oc   = sel ? oc1 : oc0;
    assign ol   = sel ? ol1 : ol0;
    assign ob   = sel ? ob1 : ob0;

    conv_encoder_k3 #(.TAIL_EN(1'b1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(v1), .i_data(data),
        .i_last(last), .o_ready(ordy1), .o_valid(ov1), .o_code(oc1),
        .o_last(ol1), .i_ready(r1), .o_busy(ob1)
    );

    conv_encoder_k3 #(.TAIL_EN(1'b0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_valid(v0), .i_data(data),
        .i_last(last), .o_ready(ordy0), .o_valid(ov0), .o_code(oc0),
        .o_last(ol0), .i_ready(r0), .o_busy(ob0)
    );

    // Monitor on the selected instance: captures handshakes {last,code},
    // flags any change during a stall, counts busy cycles with o_ready=0.
    always @(negedge clk) begin
        if (rst) begin
            hold_prev <= 1'b0;
        end else begin
            if (hold_prev && (!ov || {ol, oc} != held))
                stall_err <= stall_err + 1;
            hold_prev <= ov && !ready;
            held <= {ol, oc};
            if (ov && ready)
                cap.push_back({ol, oc});
            if (ob && !ordy)
                rdy_low <= rdy_low + 1;
        end
    end

    task automatic send_bit(input logic d, input logic l);
        bit acc;
        acc = 1'b0;
        valid = 1'b1;
        data = d;
        last = l;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = ordy;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            miscompares++;
            $display("FAIL send_bit timeout: o_ready=0 required 1");
        end
        vectors++;
        valid = 1'b0;
        data = 1'b0;
        last = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] bits, input int n);
        for (int i = 0; i < n; i++)
            send_bit(bits[i], i == n - 1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            done = !ob && !ov;
        end
        @(posedge clk);
        #1;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL wait_idle timeout: o_busy=%0b o_valid=%0b", ob, ov);
        end
    endtask

    task automatic test_reset();
        sel = 1'b1;
        rst = 1'b1;
        #2;
        vectors++;
        if ({ov1, oc1, ol1, ob1, ordy1} !== 6'b0_00_0_0_1) begin
            miscompares++;
            $display("FAIL reset dut1: v,c,l,b,r=%b required 000001",
                     {ov1, oc1, ol1, ob1, ordy1});
        end
        vectors++;
        if ({ov0, oc0, ol0, ob0} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset dut0: v,c,l,b=%b required 00000",
                     {ov0, oc0, ol0, ob0});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [2:0] exp[6];
        int base, rl;
        exp = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
        sel = 1'b1;
        ready = 1'b1;
        base = cap.size();
        rl = rdy_low;
        send_frame(8'b1101, 4);
        wait_idle();
        vectors++;
        if (cap.size() - base != 6) begin
            miscompares++;
            $display("FAIL basic count: %0d required 6", cap.size() - base);
        end
        for (int i = 0; i < 6 && base + i < cap.size(); i++) begin
            vectors++;
            if (cap[base+i] !== exp[i]) begin
                miscompares++;
                $display("FAIL basic cw%0d: %b required %b",
                         i, cap[base+i], exp[i]);
            end
        end
        vectors++;
        if (rdy_low - rl != 2) begin
            miscompares++;
            $display("FAIL basic ready_low: %0d required 2", rdy_low - rl);
        end
        vectors++;
        if (dut1.s !== 2'b00) begin
            miscompares++;
            $display("FAIL basic final_s: %b required 00", dut1.s);
        end
    endtask

    task automatic test_stall();
        logic [2:0] exp[6];
        logic [3:0] pat;
        int base, se;
        exp = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
        pat = 4'b1001;
        sel = 1'b1;
        base = cap.size();
        se = stall_err;
        fork
            begin
                send_frame(8'b1101, 4);
                wait_idle();
            end
            begin
                for (int i = 0; i < 16; i++) begin
                    ready = pat[3 - (i % 4)];
                    @(posedge clk);
                    #1;
                end
                ready = 1'b1;
            end
        join
        vectors++;
        if (cap.size() - base != 6) begin
            miscompares++;
            $display("FAIL stall count: %0d required 6", cap.size() - base);
        end
        for (int i = 0; i < 6 && base + i < cap.size(); i++) begin
            vectors++;
            if (cap[base+i] !== exp[i]) begin
                miscompares++;
                $display("FAIL stall cw%0d: %b required %b",
                         i, cap[base+i], exp[i]);
            end
        end
        vectors++;
        if (stall_err - se != 0) begin
            miscompares++;
            $display("FAIL stall hold: %0d changes required 0",
                     stall_err - se);
        end
    endtask

    task automatic test_no_tail();
        logic [2:0] exp[3];
        int base;
        exp = '{3'b011, 3'b101, 3'b101};
        sel = 1'b0;
        ready = 1'b1;
        @(posedge clk);
        #1;
        base = cap.size();
        send_frame(8'b11, 2);
        send_frame(8'b0, 1);
        wait_idle();
        vectors++;
        if (cap.size() - base != 3) begin
            miscompares++;
            $display("FAIL notail count: %0d required 3", cap.size() - base);
        end
        for (int i = 0; i < 3 && base + i < cap.size(); i++) begin
            vectors++;
            if (cap[base+i] !== exp[i]) begin
                miscompares++;
                $display("FAIL notail cw%0d: %b required %b",
                         i, cap[base+i], exp[i]);
            end
        end
        sel = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_bit();
        logic [2:0] exp[3];
        int base;
        exp = '{3'b011, 3'b010, 3'b111};
        sel = 1'b1;
        ready = 1'b1;
        base = cap.size();
        send_bit(1'b1, 1'b1);
        vectors++;
        if (ob !== 1'b1) begin
            miscompares++;
            $display("FAIL single busy_set: %b required 1", ob);
        end
        wait_idle();
        vectors++;
        if (ob !== 1'b0) begin
            miscompares++;
            $display("FAIL single busy_clr: %b required 0", ob);
        end
        vectors++;
        if (cap.size() - base != 3) begin
            miscompares++;
            $display("FAIL single count: %0d required 3", cap.size() - base);
        end
        for (int i = 0; i < 3 && base + i < cap.size(); i++) begin
            vectors++;
            if (cap[base+i] !== exp[i]) begin
                miscompares++;
                $display("FAIL single cw%0d: %b required %b",
                         i, cap[base+i], exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_tail();
        logic [2:0] exp[6];
        int base;
        exp = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
        sel = 1'b1;
        ready = 1'b1;
        send_frame(8'b1101, 4);
        rst = 1'b1;
        #1;
        vectors++;
        if ({ov1, ob1, ordy1} !== 3'b001) begin
            miscompares++;
            $display("FAIL rst_tail v,b,r: %b required 001",
                     {ov1, ob1, ordy1});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        base = cap.size();
        send_frame(8'b1101, 4);
        wait_idle();
        vectors++;
        if (cap.size() - base != 6) begin
            miscompares++;
            $display("FAIL rst_tail count: %0d required 6", cap.size() - base);
        end
        for (int i = 0; i < 6 && base + i < cap.size(); i++) begin
            vectors++;
            if (cap[base+i] !== exp[i]) begin
                miscompares++;
                $display("FAIL rst_tail cw%0d: %b required %b",
                         i, cap[base+i], exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp[8];
        int base, rl;
        exp = '{3'b011, 3'b010, 3'b011, 3'b100,
                3'b011, 3'b001, 3'b001, 3'b111};
        sel = 1'b1;
        ready = 1'b1;
        base = cap.size();
        rl = rdy_low;
        send_frame(8'b01, 2);
        send_frame(8'b11, 2);
        wait_idle();
        vectors++;
        if (cap.size() - base != 8) begin
            miscompares++;
            $display("FAIL b2b count: %0d required 8", cap.size() - base);
        end
        for (int i = 0; i < 8 && base + i < cap.size(); i++) begin
            vectors++;
            if (cap[base+i] !== exp[i]) begin
                miscompares++;
                $display("FAIL b2b cw%0d: %b required %b",
                         i, cap[base+i], exp[i]);
            end
        end
        vectors++;
        if (rdy_low - rl != 4) begin
            miscompares++;
            $display("FAIL b2b ready_low: %0d required 4", rdy_low - rl);
        end
        vectors++;
        if (dut1.s !== 2'b00) begin
            miscompares++;
            $display("FAIL b2b final_s: %b required 00", dut1.s);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_no_tail();
        test_single_bit();
        test_reset_mid_tail();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
